inst_rom_resp: RTL and testbench

Instruction-memory responder on the far side of the core's fetch port. The core drives the fetch address and chip enable and receives the instruction word back; this block returns that word. It holds a word array filled at boot by a byte-serial loader. A configurable wait-state counter lets a slow ROM stall the fetch stage.

---
 rtl/inst_rom_resp_pkg.sv | 18 +
 rtl/inst_rom_resp_if.sv | 32 +++
 rtl/inst_rom_loader.sv | 54 +++++
 rtl/inst_rom_resp.sv | 116 +++++++++++
 tb/tb_inst_rom_resp.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_rom_resp_pkg.sv
// Shared types and constants for the instruction-ROM responder and its byte loader.
// Bus widths follow the core's fetch-port definitions.
package inst_rom_resp_pkg;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;

  typedef logic [31:0] inst_addr_bus_t;
  typedef logic [31:0] inst_bus_t;
  typedef logic [7:0]  rom_ld_byte_bus_t;

  // True when every address bit above the stored word range is zero.
  function automatic logic addr_in_range(input inst_addr_bus_t addr, input int depth_log2);
    return (addr >> (depth_log2 + 2)) == '0;
  endfunction

endpackage

// File: rtl/inst_rom_resp_if.sv
// Fetch port and boot-loader port bundle between the core side and the ROM responder.
// master = core/loader driver, slave = ROM.
interface inst_rom_resp_if
  import inst_rom_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
);

  logic                  ce_i;
  inst_addr_bus_t        addr_i;
  inst_bus_t             data_o;
  logic                  stall_o;
  logic                  err_o;

  logic                  ld_start_i;
  logic                  ld_valid_i;
  rom_ld_byte_bus_t      ld_byte_i;
  logic                  ld_ready_o;
  logic                  ld_full_o;
  logic [DEPTH_LOG2:0]   ld_count_o;

  modport master (
    output ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i,
    input  data_o, stall_o, err_o, ld_ready_o, ld_full_o, ld_count_o
  );

  modport slave (
    input  ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i,
    output data_o, stall_o, err_o, ld_ready_o, ld_full_o, ld_count_o
  );

endinterface

// File: rtl/inst_rom_loader.sv
// Byte-serial boot loader: assembles big-endian bytes into words and emits one
// write strobe per completed word until the array is full.
module inst_rom_loader
  import inst_rom_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  rom_ld_byte_bus_t      ld_byte,
  output logic                  ld_ready,
  output logic                  ld_full,
  output logic [DEPTH_LOG2:0]   ld_count,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output inst_bus_t             wr_data
);

  logic [1:0]          byte_idx_reg;
  logic [DEPTH_LOG2:0] word_ptr_reg;
  logic [23:0]         shift_reg;
  logic                accept;

  // word_ptr counts up to exactly DEPTH, so its top bit alone marks "full".
  assign ld_full  = word_ptr_reg[DEPTH_LOG2];
  assign ld_ready = !ld_full;
  assign ld_count = word_ptr_reg;

  assign accept  = ld_valid && ld_ready && !ld_start;
  assign wr_en   = accept && (byte_idx_reg == 2'd3);
  assign wr_addr = word_ptr_reg[DEPTH_LOG2-1:0];
  assign wr_data = {shift_reg, ld_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_reg <= 2'd0;
      word_ptr_reg <= '0;
      shift_reg    <= '0;
    end else if (ld_start) begin
      byte_idx_reg <= 2'd0;
      word_ptr_reg <= '0;
      shift_reg    <= '0;
    end else if (accept) begin
      shift_reg    <= {shift_reg[15:0], ld_byte};
      byte_idx_reg <= byte_idx_reg + 2'd1;
      if (wr_en) begin
        word_ptr_reg <= word_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction-ROM responder: word array filled by the byte loader, combinational
// fetch read, and an optional wait-state FSM that stalls each new fetch address.
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst,
  inst_rom_resp_if.slave bus
);

  localparam int         DEPTH         = 1 << DEPTH_LOG2;
  localparam int         WAIT_LOAD_INT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [2:0] WAIT_LOAD     = 3'(WAIT_LOAD_INT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  inst_bus_t             wr_data;

  inst_rom_loader #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ld_start (bus.ld_start_i),
    .ld_valid (bus.ld_valid_i),
    .ld_byte  (bus.ld_byte_i),
    .ld_ready (bus.ld_ready_o),
    .ld_full  (bus.ld_full_o),
    .ld_count (bus.ld_count_o),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  inst_bus_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  in_range;
  logic                  ce_on;
  inst_bus_t             rd_word;

  assign word_idx = bus.addr_i[DEPTH_LOG2+1:2];
  assign in_range = addr_in_range(bus.addr_i, DEPTH_LOG2);
  assign ce_on    = (bus.ce_i == ChipEnable);
  // Read is combinational so a write landing this edge is only seen next cycle.
  assign rd_word  = mem[word_idx];

  assign bus.data_o = (ce_on && in_range) ? rd_word : ZeroWord;
  assign bus.err_o  = ce_on && !in_range;

  logic [0:0]     state_reg;
  logic [0:0]     state_next;
  logic [2:0]     wait_cnt_reg;
  logic [2:0]     wait_cnt_next;
  logic           last_valid_reg;
  inst_addr_bus_t last_addr_reg;
  logic           fetch_ok;
  logic           new_fetch;
  logic           stall;

  // Gated by rst so an asserted reset drops the stall without waiting for an edge.
  assign fetch_ok  = rst && ce_on && in_range;
  assign new_fetch = fetch_ok && (!last_valid_reg || (bus.addr_i != last_addr_reg));

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    stall         = 1'b0;
    if (WAIT_STATES == 0 || !fetch_ok) begin
      state_next    = ST_IDLE;
      wait_cnt_next = 3'd0;
    end else if (new_fetch) begin
      // A new address, including one arriving mid-wait, restarts the full count.
      stall         = 1'b1;
      wait_cnt_next = WAIT_LOAD;
      state_next    = (WAIT_LOAD != 3'd0) ? ST_WAIT : ST_IDLE;
    end else if (state_reg == ST_WAIT) begin
      stall         = 1'b1;
      wait_cnt_next = wait_cnt_reg - 3'd1;
      if (wait_cnt_next == 3'd0) begin
        state_next = ST_IDLE;
      end
    end
  end

  assign bus.stall_o = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      wait_cnt_reg   <= 3'd0;
      last_valid_reg <= 1'b0;
      last_addr_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      last_valid_reg <= ce_on;
      if (ce_on) begin
        last_addr_reg <= bus.addr_i;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench for inst_rom_resp: two instances (0 and 2 wait states) share one stimulus
// stream and are checked every cycle against a behavioural ROM/loader model.
module tb_inst_rom_resp;
  import inst_rom_resp_pkg::*;

  localparam int DL2   = 10;
  localparam int DEPTH = 1 << DL2;
  localparam int NWS   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;

  always #5 clk = ~clk;

  inst_rom_resp_if #(.DEPTH_LOG2(DL2)) bus0 ();
  inst_rom_resp_if #(.DEPTH_LOG2(DL2)) bus2 ();

  assign bus0.ce_i = ce;        assign bus2.ce_i = ce;
  assign bus0.addr_i = addr;    assign bus2.addr_i = addr;
  assign bus0.ld_start_i = ld_start; assign bus2.ld_start_i = ld_start;
  assign bus0.ld_valid_i = ld_valid; assign bus2.ld_valid_i = ld_valid;
  assign bus0.ld_byte_i = ld_byte;   assign bus2.ld_byte_i = ld_byte;

  inst_rom_resp #(.DEPTH_LOG2(DL2), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  inst_rom_resp #(.DEPTH_LOG2(DL2), .WAIT_STATES(NWS)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ROM contents, loader progress, age of the current fetch address.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  int          m_cnt = 0;
  int          m_nb = 0;
  logic [31:0] m_word = 32'h0;
  bit          m_pv = 1'b0;
  logic [31:0] m_pa = 32'h0;
  int          m_age = 0;

  always @(negedge clk) begin
    bit          inr;
    int          idx;
    bit          exp_st;
    bit          chk_d;
    logic [31:0] exp_d;
    if (!rst) begin
      m_cnt = 0; m_nb = 0; m_word = 32'h0; m_pv = 1'b0; m_age = 0;
    end
    inr = (addr[31:12] == 20'h0);
    idx = int'(addr[11:2]);
    if (ce && inr) begin
      if (m_pv && addr == m_pa) begin
        if (m_age < 100) m_age++;
      end else begin
        m_age = 0;
      end
    end
    exp_st = rst && ce && inr && (m_age < NWS);
    chk_d = 1'b1;
    exp_d = 32'h0;
    if (ce && inr) begin
      chk_d = m_known[idx];
      exp_d = m_mem[idx];
    end
    chk("err0", 32'(bus0.err_o), 32'(ce && !inr));
    chk("err2", 32'(bus2.err_o), 32'(ce && !inr));
    chk("stall0", 32'(bus0.stall_o), 32'h0);
    chk("stall2", 32'(bus2.stall_o), 32'(exp_st));
    if (chk_d) chk("data0", bus0.data_o, exp_d);
    if (chk_d && !exp_st) chk("data2", bus2.data_o, exp_d);
    chk("count0", 32'(bus0.ld_count_o), 32'(m_cnt));
    chk("count2", 32'(bus2.ld_count_o), 32'(m_cnt));
    chk("full0", 32'(bus0.ld_full_o), 32'(m_cnt == DEPTH));
    chk("ready0", 32'(bus0.ld_ready_o), 32'(m_cnt != DEPTH));
    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      m_pv = ce;
      m_pa = addr;
      if (ld_start) begin
        m_cnt = 0; m_nb = 0;
      end else if (ld_valid && m_cnt < DEPTH) begin
        m_word = {m_word[23:0], ld_byte};
        m_nb++;
        if (m_nb == 4) begin
          m_mem[m_cnt] = m_word;
          m_known[m_cnt] = 1'b1;
          m_cnt++;
          m_nb = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  boot_bytes [8] = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
  logic [31:0] a_seq [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h4};
  bit          st_seq [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] d_seq [7] = '{32'h34011100, 32'h34011100, 32'h34011100, 32'h34011100,
                             32'h34020020, 32'h34020020, 32'h34020020};
  logic [7:0]  tail_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0]  fill_head [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int hold;
    int r;
    hold = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready", 32'(bus0.ld_ready_o), 32'h1);
    chk("rst_count", 32'(bus0.ld_count_o), 32'h0);
    chk("rst_full", 32'(bus2.ld_full_o), 32'h0);
    tick();
    rst = 1'b1;

    // Boot load of two words.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_byte = boot_bytes[i]; tick();
    end
    ld_valid = 1'b0;
    @(negedge clk);
    chk("boot_count", 32'(bus0.ld_count_o), 32'h2);
    chk("boot_ready", 32'(bus0.ld_ready_o), 32'h1);
    chk("model_mem1", m_mem[1], 32'h34020020);
    tick();

    // Fetch sequence: same-cycle data on dut0, two-cycle stall per new address on dut2.
    ce = 1'b1;
    for (int i = 0; i < 7; i++) begin
      addr = a_seq[i];
      @(negedge clk);
      chk("seq_data0", bus0.data_o, d_seq[i]);
      chk("seq_stall2", 32'(bus2.stall_o), 32'(st_seq[i]));
      if (!st_seq[i]) chk("seq_data2", bus2.data_o, d_seq[i]);
      tick();
    end

    ce = 1'b0;
    @(negedge clk);
    chk("off_data", bus0.data_o, 32'h0);
    chk("off_stall", 32'(bus2.stall_o), 32'h0);
    tick();
    ce = 1'b1; addr = 32'h0001_0000;
    @(negedge clk);
    chk("oor_err", 32'(bus0.err_o), 32'h1);
    chk("oor_data", bus2.data_o, 32'h0);
    chk("oor_stall", 32'(bus2.stall_o), 32'h0);
    tick();

    // Reset in the middle of a stall drops stall_o at once.
    addr = 32'h8;
    @(negedge clk);
    chk("pre_rst_stall", 32'(bus2.stall_o), 32'h1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(bus2.stall_o), 32'h0);
    tick();
    rst = 1'b1; ce = 1'b0;

    // Randomized fetch and load traffic.
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        r = int'($urandom_range(0, 9));
        ce = (r != 0);
        if (r == 1)
          addr = (32'd1 << $urandom_range(12, 31)) | (32'($urandom_range(0, 1023)) << 2);
        else if (r == 2)
          addr = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(0, 3));
        else
          addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        hold = int'($urandom_range(0, 4));
      end else begin
        hold--;
      end
      ld_start = ($urandom_range(0, 99) == 0);
      ld_valid = ($urandom_range(0, 2) != 0);
      ld_byte  = 8'($urandom);
      tick();
    end
    ld_start = 1'b0; ld_valid = 1'b0;

    // Fill the whole array while reading low words.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_byte  = (i < 4) ? fill_head[i] : 8'($urandom);
      ce   = 1'b1;
      addr = 32'($urandom_range(0, 15)) << 2;
      tick();
    end
    ld_byte = 8'hEE; tick();
    ld_valid = 1'b0; addr = 32'h0;
    @(negedge clk);
    chk("fill_count", 32'(bus0.ld_count_o), 32'd1024);
    chk("fill_full", 32'(bus2.ld_full_o), 32'h1);
    chk("fill_ready", 32'(bus0.ld_ready_o), 32'h0);
    chk("fill_mem0", bus0.data_o, 32'h11223344);
    tick();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    @(negedge clk);
    chk("restart_full", 32'(bus0.ld_full_o), 32'h0);
    chk("restart_count", 32'(bus0.ld_count_o), 32'h0);
    tick();

    // Reset during a partial word, then a clean word.
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_byte = 8'($urandom); tick();
    end
    ld_valid = 1'b0; rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_byte = tail_bytes[i]; tick();
    end
    ld_valid = 1'b0; ce = 1'b1; addr = 32'h0;
    @(negedge clk);
    chk("reload_mem0", bus0.data_o, 32'hAABBCCDD);
    chk("reload_count", 32'(bus0.ld_count_o), 32'h1);
    chk("model_mem0", m_mem[0], 32'hAABBCCDD);
    tick();
    ce = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
